// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between two fetch requesters.
// The request and response paths are purely combinational; the only state is
// a small FIFO recording which requester owns each outstanding memory request,
// the round-robin pointer, the stall lock and a sticky orphan-response flag.
module imem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic                  req_valid0,
  input  logic                  req_valid1,
  output logic                  req_ready0,
  output logic                  req_ready1,
  output logic [DATA_WIDTH-1:0] rsp_data0,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  input  logic                  rsp_ready0,
  input  logic                  rsp_ready1,
  output logic [ADDR_WIDTH-1:0] mem_pc,
  output logic                  mem_pc_valid,
  input  logic                  mem_pc_ready,
  input  logic [DATA_WIDTH-1:0] mem_instr,
  input  logic                  mem_instr_valid,
  output logic                  mem_instr_ready,
  output logic                  err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // owner FIFO: one bit per entry, 0 = requester 0, 1 = requester 1
  logic [DEPTH-1:0] owner_q;
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             last_grant;
  logic             lock;
  logic             locked_id;
  logic             err_orphan_q;

  logic grant;
  logic req_valid_g;
  logic fifo_empty;
  logic fifo_full;
  logic head;
  logic pop;
  logic push;
  logic can_push;

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = owner_q[rd_ptr[PW-1:0]];
  assign err_orphan = err_orphan_q;
  assign rsp_data0  = mem_instr;
  assign rsp_data1  = mem_instr;

  // Grant selection: a stalled request keeps the grant, otherwise round-robin on ties.
  always_comb begin
    grant = ~last_grant;
    if (lock) begin
      grant = locked_id;
    end else if (req_valid0 && !req_valid1) begin
      grant = 1'b0;
    end else if (req_valid1 && !req_valid0) begin
      grant = 1'b1;
    end
  end

  // Request/response steering; request side is held off while in reset.
  always_comb begin
    req_valid_g     = grant ? req_valid1 : req_valid0;
    mem_pc          = grant ? req_addr1 : req_addr0;
    mem_instr_ready = fifo_empty ? 1'b1 : (head ? rsp_ready1 : rsp_ready0);
    pop             = mem_instr_valid && mem_instr_ready;
    can_push        = !fifo_full || pop;
    mem_pc_valid    = async_rst_n && req_valid_g && can_push;
    req_ready0      = async_rst_n && !grant && mem_pc_ready && can_push;
    req_ready1      = async_rst_n && grant && mem_pc_ready && can_push;
    rsp_valid0      = !fifo_empty && !head && mem_instr_valid;
    rsp_valid1      = !fifo_empty && head && mem_instr_valid;
    push            = mem_pc_valid && mem_pc_ready;
  end

  // Owner FIFO write side; records who owns each accepted memory request.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      owner_q <= '0;
      wr_ptr  <= '0;
    end else if (push) begin
      owner_q[wr_ptr[PW-1:0]] <= grant;
      wr_ptr                  <= wr_ptr + PTR_ONE;
    end
  end

  // Owner FIFO read side; an orphan response pops nothing.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_ptr <= '0;
    end else if (pop && !fifo_empty) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Round-robin pointer and stall lock; last_grant=1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_grant <= 1'b1;
      lock       <= 1'b0;
      locked_id  <= 1'b0;
    end else if (push) begin
      last_grant <= grant;
      lock       <= 1'b0;
    end else if (mem_pc_valid && !mem_pc_ready) begin
      lock      <= 1'b1;
      locked_id <= grant;
    end
  end

  // Sticky flag for a memory response that nobody asked for.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      err_orphan_q <= 1'b0;
    end else if (mem_instr_valid && fifo_empty) begin
      err_orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus a random phase, checked against a
// queue-based reference model of outstanding requests and the grant rules.
module tb_imem_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        async_rst_n;
  logic [31:0] req_addr0, req_addr1;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] rsp_data0, rsp_data1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] mem_pc;
  logic        mem_pc_valid, mem_pc_ready;
  logic [31:0] mem_instr;
  logic        mem_instr_valid, mem_instr_ready;
  logic        err_orphan;

  imem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .mem_pc(mem_pc), .mem_pc_valid(mem_pc_valid), .mem_pc_ready(mem_pc_ready),
    .mem_instr(mem_instr), .mem_instr_valid(mem_instr_valid),
    .mem_instr_ready(mem_instr_ready), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } ent_t;

  // reference model: outstanding requests in memory order
  ent_t mq[$];
  int   last_g, lk, lk_id;
  bit   orph;

  int checks, passed;

  logic        obs_mpv, obs_rr0, obs_rr1, obs_rv0, obs_rv1, obs_mir, obs_err;
  logic [31:0] obs_mpc;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    last_g = 1;
    lk     = 0;
    lk_id  = 0;
    orph   = 0;
  endtask

  // one clock: inputs already driven at posedge+1; check at negedge; step model at posedge
  task automatic cycle();
    int   g, head;
    bit   empty, full, mir, pp, cp, mpv, rv0, rv1;
    logic [31:0] a_g;
    if (mq.size() > 0) mem_instr = mq[0].data;
    else mem_instr = $urandom;
    #4;
    if (lk != 0) g = lk_id;
    else if (req_valid0 && !req_valid1) g = 0;
    else if (req_valid1 && !req_valid0) g = 1;
    else g = 1 - last_g;
    empty = (mq.size() == 0);
    full  = (mq.size() == DEPTH);
    head  = empty ? 0 : mq[0].owner;
    mir   = empty ? 1'b1 : ((head == 1) ? rsp_ready1 : rsp_ready0);
    pp    = mem_instr_valid && mir;
    cp    = !full || pp;
    mpv   = ((g == 1) ? req_valid1 : req_valid0) && cp;
    a_g   = (g == 1) ? req_addr1 : req_addr0;
    rv0   = !empty && mem_instr_valid && head == 0;
    rv1   = !empty && mem_instr_valid && head == 1;
    obs_mpv = mem_pc_valid; obs_mpc = mem_pc; obs_rr0 = req_ready0; obs_rr1 = req_ready1;
    obs_rv0 = rsp_valid0; obs_rv1 = rsp_valid1; obs_mir = mem_instr_ready; obs_err = err_orphan;
    chk("mem_pc_valid", {63'd0, mem_pc_valid}, {63'd0, mpv});
    if (mpv) chk("mem_pc", {32'd0, mem_pc}, {32'd0, a_g});
    chk("req_ready0", {63'd0, req_ready0}, {63'd0, (g == 0) && mem_pc_ready && cp});
    chk("req_ready1", {63'd0, req_ready1}, {63'd0, (g == 1) && mem_pc_ready && cp});
    chk("mem_instr_ready", {63'd0, mem_instr_ready}, {63'd0, mir});
    chk("rsp_valid0", {63'd0, rsp_valid0}, {63'd0, rv0});
    chk("rsp_valid1", {63'd0, rsp_valid1}, {63'd0, rv1});
    if (rv0) chk("rsp_data0", {32'd0, rsp_data0}, {32'd0, mq[0].data});
    if (rv1) chk("rsp_data1", {32'd0, rsp_data1}, {32'd0, mq[0].data});
    chk("err_orphan", {63'd0, err_orphan}, {63'd0, orph});
    @(posedge clk);
    if (pp) begin
      if (!empty) void'(mq.pop_front());
      else orph = 1;
    end
    if (mpv && mem_pc_ready) begin
      mq.push_back('{owner: g, data: fdat(a_g)});
      last_g = g;
      lk     = 0;
    end else if (mpv) begin
      lk    = 1;
      lk_id = g;
    end
    #1;
  endtask

  task automatic drain();
    req_valid0 = 0; req_valid1 = 0;
    rsp_ready0 = 1; rsp_ready1 = 1;
    for (int i = 0; i < 20 && mq.size() > 0; i++) begin
      mem_instr_valid = 1;
      cycle();
    end
    mem_instr_valid = 0;
    chk("drain_empty", {32'd0, mq.size()}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready0"}, {63'd0, req_ready0}, 64'd0);
    chk({tag, "_req_ready1"}, {63'd0, req_ready1}, 64'd0);
    chk({tag, "_mem_pc_valid"}, {63'd0, mem_pc_valid}, 64'd0);
    chk({tag, "_rsp_valid0"}, {63'd0, rsp_valid0}, 64'd0);
    chk({tag, "_rsp_valid1"}, {63'd0, rsp_valid1}, 64'd0);
    chk({tag, "_mem_instr_ready"}, {63'd0, mem_instr_ready}, 64'd1);
    chk({tag, "_err_orphan"}, {63'd0, err_orphan}, 64'd0);
  endtask

  logic [31:0] lock_addr;

  initial begin
    checks = 0; passed = 0;
    model_reset();
    async_rst_n = 0;
    req_addr0 = 32'h0000_1000; req_addr1 = 32'h0000_2000;
    req_valid0 = 1; req_valid1 = 1;
    rsp_ready0 = 1; rsp_ready1 = 1;
    mem_pc_ready = 1; mem_instr = '0; mem_instr_valid = 1;

    // reset state with busy inputs
    #2;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    async_rst_n = 1;
    mem_instr_valid = 0;

    // tie: both valid, memory always ready -> 0,1,0,1 grants and responses
    for (int i = 0; i < 6; i++) begin
      req_addr0 = $urandom; req_addr1 = $urandom;
      mem_instr_valid = (mq.size() > 0);
      cycle();
      chk("tie_grant0", {63'd0, obs_rr0}, {63'd0, (i % 2) == 0});
      chk("tie_grant1", {63'd0, obs_rr1}, {63'd0, (i % 2) == 1});
      if (i > 0) begin
        chk("tie_rsp0", {63'd0, obs_rv0}, {63'd0, ((i - 1) % 2) == 0});
        chk("tie_rsp1", {63'd0, obs_rv1}, {63'd0, ((i - 1) % 2) == 1});
      end
    end
    drain();

    // lock: make requester 0 the last grant so a tie would favour requester 1
    req_valid0 = 1; req_valid1 = 0; mem_pc_ready = 1;
    cycle();
    drain();
    lock_addr = 32'hCAFE_0040;
    req_addr0 = lock_addr; req_addr1 = 32'hBEEF_0080;
    req_valid0 = 1; req_valid1 = 0; mem_pc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) req_valid1 = 1;
      cycle();
      chk("lock_pc", {32'd0, obs_mpc}, {32'd0, lock_addr});
      chk("lock_rr1", {63'd0, obs_rr1}, 64'd0);
    end
    mem_pc_ready = 1;
    cycle();
    chk("lock_accept0", {63'd0, obs_rr0}, 64'd1);
    chk("lock_pc_accept", {32'd0, obs_mpc}, {32'd0, lock_addr});
    cycle();
    chk("lock_then_req1", {63'd0, obs_rr1}, 64'd1);
    drain();

    // full: responses stalled, two accepts, then one response frees a slot
    rsp_ready0 = 0; rsp_ready1 = 0;
    req_valid0 = 1; req_valid1 = 1; mem_pc_ready = 1; mem_instr_valid = 0;
    cycle();
    cycle();
    cycle();
    chk("full_mpv", {63'd0, obs_mpv}, 64'd0);
    chk("full_rr0", {63'd0, obs_rr0}, 64'd0);
    chk("full_rr1", {63'd0, obs_rr1}, 64'd0);
    mem_instr_valid = 1; rsp_ready0 = 1;
    cycle();
    chk("full_pulse_mpv", {63'd0, obs_mpv}, 64'd1);
    chk("full_pulse_mir", {63'd0, obs_mir}, 64'd1);
    rsp_ready0 = 0;
    cycle();
    chk("full_again_mpv", {63'd0, obs_mpv}, 64'd0);

    // head-of-line: pop the requester-1 head, leaving a requester-0 head
    req_valid0 = 0; req_valid1 = 0;
    rsp_ready0 = 0; rsp_ready1 = 1; mem_instr_valid = 1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("hol_rv1", {63'd0, obs_rv1}, 64'd0);
      chk("hol_mir", {63'd0, obs_mir}, 64'd0);
      chk("hol_rv0", {63'd0, obs_rv0}, 64'd1);
    end
    rsp_ready0 = 1;
    cycle();
    chk("hol_release_mir", {63'd0, obs_mir}, 64'd1);
    drain();

    // orphan: response with nothing outstanding
    mem_instr_valid = 1;
    cycle();
    chk("orphan_before", {63'd0, obs_err}, 64'd0);
    mem_instr_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("orphan_sticky", {63'd0, obs_err}, 64'd1);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_addr0 = $urandom; req_addr1 = $urandom;
      req_valid0 = $urandom_range(0, 1) != 0;
      req_valid1 = $urandom_range(0, 1) != 0;
      mem_pc_ready = $urandom_range(0, 3) != 0;
      rsp_ready0 = $urandom_range(0, 3) != 0;
      rsp_ready1 = $urandom_range(0, 3) != 0;
      mem_instr_valid = (mq.size() > 0) && ($urandom_range(0, 1) != 0);
      cycle();
    end
    drain();

    // reset mid-stream with two outstanding
    rsp_ready0 = 0; rsp_ready1 = 0;
    req_valid0 = 1; req_valid1 = 1; mem_pc_ready = 1; mem_instr_valid = 0;
    cycle();
    cycle();
    chk("pre_reset_outstanding", {32'd0, mq.size()}, 64'd2);
    mem_instr_valid = 1; rsp_ready0 = 1; rsp_ready1 = 1;
    async_rst_n = 0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    async_rst_n = 1;
    mem_instr_valid = 0;
    cycle();
    chk("post_reset_grant0", {63'd0, obs_rr0}, 64'd1);
    chk("post_reset_grant1", {63'd0, obs_rr1}, 64'd0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 2, max outstanding requests (owner FIFO entries, power of 2, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port async_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_addr0/req_addr1  input  ADDR_WIDTH  requester 0/1 fetch address.
REQ-007 SHALL have ports req_valid0/req_valid1  input  1  requester 0/1 request valid.
REQ-008 SHALL have ports req_ready0/req_ready1  output  1  requester 0/1 request accepted.
REQ-009 SHALL have ports rsp_data0/rsp_data1  output  DATA_WIDTH  instruction returned to requester 0/1.
REQ-010 SHALL have ports rsp_valid0/rsp_valid1  output  1  response valid to requester 0/1.
REQ-011 SHALL have ports rsp_ready0/rsp_ready1  input  1  requester 0/1 can take a response.
REQ-012 SHALL have ports mem_pc  output  ADDR_WIDTH, mem_pc_valid  output  1, mem_pc_ready  input  1: request channel to the instruction memory.
REQ-013 SHALL have ports mem_instr  input  DATA_WIDTH, mem_instr_valid  input  1, mem_instr_ready  output  1: response channel from the instruction memory.
REQ-014 SHALL have port err_orphan  output  1  sticky: response arrived with no owner recorded.

Function
REQ-015 SHALL share one instruction memory between two requesters; all channels use valid/ready, transfer when valid && ready on a rising edge.
REQ-016 SHALL select grant g combinationally: if lock set, g = locked_id; else if exactly one req_valid, that requester; else if both, the requester != last_grant (round-robin).
REQ-017 SHALL drive mem_pc = req_addr[g], mem_pc_valid = req_valid[g] && can_push.
REQ-018 SHALL define can_push = !fifo_full || pop, where pop = mem_instr_valid && mem_instr_ready.
REQ-019 SHALL drive req_ready[g] = mem_pc_ready && can_push; req_ready of the non-granted requester SHALL be 0.
REQ-020 SHALL on accept (mem_pc_valid && mem_pc_ready) push g into owner FIFO and set last_grant = g.
REQ-021 SHALL set lock=1, locked_id=g when mem_pc_valid && !mem_pc_ready; clear lock on accept; a presented request is never switched to the other requester before acceptance.
REQ-022 SHALL route responses to FIFO head h: rsp_valid[h] = mem_instr_valid, rsp_valid[other] = 0, both rsp_data = mem_instr, mem_instr_ready = rsp_ready[h] when FIFO non-empty.
REQ-023 SHALL when FIFO empty drive mem_instr_ready = 1, both rsp_valid = 0, and set err_orphan on mem_instr_valid (sticky until reset).
REQ-024 SHALL pop FIFO head on pop; simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-025 SHALL add zero cycles of latency: request and response paths are combinational through the arbiter; the only state is owner FIFO, last_grant, lock, locked_id, err_orphan.
REQ-026 SHALL preserve response order per memory order; a stalled requester (rsp_ready=0) blocks responses to both requesters (head-of-line).
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH, with an extra bit to distinguish full from empty.

Reset
REQ-028 SHALL on async_rst_n low immediately empty the FIFO and clear lock, locked_id=0, last_grant=1 (requester 0 wins first tie), err_orphan=0.
REQ-029 SHALL during reset drive req_ready0/1=0, mem_pc_valid=0, rsp_valid0/1=0, mem_instr_ready=1.
REQ-030 SHALL discard outstanding ownership on reset mid-operation; memory is reset together with the arbiter.

Verification
REQ-031 SHALL verify tie: both requesters valid every cycle, memory always ready -> grants alternate 0,1,0,1; responses routed to 0,1,0,1 with matching instructions.
REQ-032 SHALL verify lock: req0 valid, mem_pc_ready=0 for 3 cycles, req1 asserts in cycle 2 -> mem_pc stays req_addr0 until accept; req1 granted the cycle after.
REQ-033 SHALL verify full: DEPTH=2, both rsp_ready=0, requests pending -> after 2 accepts mem_pc_valid=0, req_ready=0; one rsp_ready pulse -> pop and push in same cycle, occupancy stays 2.
REQ-034 SHALL verify head-of-line: head owner 0 with rsp_ready0=0, rsp_ready1=1 -> rsp_valid1=0, mem_instr_ready=0 until rsp_ready0=1.
REQ-035 SHALL verify orphan: force mem_instr_valid=1 with FIFO empty -> err_orphan=1 next edge and stays 1 until reset.
REQ-036 SHALL verify reset mid-stream: assert async_rst_n low with 2 outstanding -> outputs at reset values immediately; after release first tie grants requester 0.
